rv64_single_cycle_processor: RTL and testbench



---
 rtl/rv64_single_cycle_processor.sv | 208 ++++++++++++++++++++
 tb/tb_rv64_single_cycle_processor.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/rv64_single_cycle_processor.sv
// Single-cycle RV64I subset core (ld, sd, add, sub, and, or, addi, beq) with
// internal instruction memory, register file and data memory.

module rv64_if_stage (
    input  logic        clk,
    input  logic        load_en,
    input  logic [7:0]  load_addr,
    input  logic [31:0] load_data,
    input  logic [7:0]  addr,
    output logic [31:0] instruction
);
    localparam int unsigned IMEM_WORDS = 256;

    logic [31:0] instr_mem [0:IMEM_WORDS-1];

    // Preload port; normally idle, contents are loaded from outside the core.
    always_ff @(posedge clk) begin
        if (load_en) instr_mem[load_addr] <= load_data;
    end

    assign instruction = instr_mem[addr];
endmodule

module rv64_id_stage (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [63:0] wd,
    output logic [63:0] rd1,
    output logic [63:0] rd2
);
    logic [63:0] registers [0:31];

    always_ff @(posedge clk) begin
        if (we && rd != 5'd0) registers[rd] <= wd;
    end

    assign rd1 = (rs1 == 5'd0) ? '0 : registers[rs1];
    assign rd2 = (rs2 == 5'd0) ? '0 : registers[rs2];
endmodule

module rv64_mem_stage (
    input  logic        clk,
    input  logic        we,
    input  logic        re,
    input  logic [7:0]  addr,
    input  logic [63:0] wd,
    output logic [63:0] rd
);
    localparam int unsigned DMEM_DWORDS = 256;

    logic [63:0] mem [0:DMEM_DWORDS-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wd;
    end

    assign rd = re ? mem[addr] : '0;
endmodule

module rv64_single_cycle_processor (
    input  logic clk,
    input  logic reset
);
    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_OPIMM  = 7'b0010011,
        OP_OP     = 7'b0110011,
        OP_BRANCH = 7'b1100011
    } opcode_t;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_ctl_t;

    logic [63:0] pc_current, pc_next;
    logic [31:0] instruction;
    logic [63:0] read_data1, read_data2, imm_ext;
    logic        reg_write, alu_src, branch, mem_read, mem_write, mem_to_reg;
    logic [1:0]  alu_op;
    logic [63:0] alu_result, alu_b;
    logic        zero, branch_taken;
    logic [63:0] alu_result_mem, read_data_mem;
    logic [4:0]  write_reg;
    logic [63:0] write_data_reg;
    logic        reg_write_wb;
    logic        rtype_ok;
    alu_ctl_t    alu_ctl;

    logic [2:0] funct3;
    logic [6:0] funct7;
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    rv64_if_stage if_stage (
        .clk         (clk),
        .load_en     (1'b0),
        .load_addr   ('0),
        .load_data   ('0),
        .addr        (pc_current[9:2]),
        .instruction (instruction)
    );

    rv64_id_stage id_stage (
        .clk (clk),
        .we  (reg_write_wb & reset),
        .rs1 (instruction[19:15]),
        .rs2 (instruction[24:20]),
        .rd  (instruction[11:7]),
        .wd  (write_data_reg),
        .rd1 (read_data1),
        .rd2 (read_data2)
    );

    assign rtype_ok = (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000))
                   || funct3 == 3'b111 || funct3 == 3'b110;

    always_comb begin
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        imm_ext    = {{52{instruction[31]}}, instruction[31:20]};
        case (instruction[6:0])
            OP_LOAD: if (funct3 == 3'b011) begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
            end
            OP_STORE: begin
                imm_ext = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
                if (funct3 == 3'b011) begin
                    alu_src   = 1'b1;
                    mem_write = 1'b1;
                end
            end
            OP_OPIMM: if (funct3 == 3'b000) begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            OP_OP: begin
                alu_op    = 2'b10;
                reg_write = rtype_ok;
            end
            OP_BRANCH: begin
                imm_ext = {{52{instruction[31]}}, instruction[7], instruction[30:25],
                           instruction[11:8], 1'b0};
                alu_op  = 2'b01;
                branch  = (funct3 == 3'b000);
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_ctl = ALU_ADD;
        case (alu_op)
            2'b01: alu_ctl = ALU_SUB;
            2'b10: case (funct3)
                3'b000:  alu_ctl = funct7[5] ? ALU_SUB : ALU_ADD;
                3'b111:  alu_ctl = ALU_AND;
                3'b110:  alu_ctl = ALU_OR;
                default: alu_ctl = ALU_ADD;
            endcase
            default: alu_ctl = ALU_ADD;
        endcase
    end

    assign alu_b = alu_src ? imm_ext : read_data2;

    always_comb begin
        case (alu_ctl)
            ALU_SUB: alu_result = read_data1 - alu_b;
            ALU_AND: alu_result = read_data1 & alu_b;
            ALU_OR:  alu_result = read_data1 | alu_b;
            default: alu_result = read_data1 + alu_b;
        endcase
    end

    assign zero         = (alu_result == '0);
    assign branch_taken = branch & zero;

    rv64_mem_stage mem_stage (
        .clk  (clk),
        .we   (mem_write & reset),
        .re   (mem_read),
        .addr (alu_result[10:3]),
        .wd   (read_data2),
        .rd   (read_data_mem)
    );

    assign alu_result_mem = alu_result;
    assign write_data_reg = mem_to_reg ? read_data_mem : alu_result_mem;
    assign write_reg      = instruction[11:7];
    assign reg_write_wb   = reg_write;

    assign pc_next = branch_taken ? pc_current + imm_ext : pc_current + 64'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_current <= '0;
        else        pc_current <= pc_next;
    end
endmodule

// File: tb/tb_rv64_single_cycle_processor.sv
// Directed bench for rv64_single_cycle_processor: scripted program from the
// test plan plus a table of single-instruction vectors.

module tb_rv64_single_cycle_processor;
    logic clk;
    logic reset;

    int unsigned n_pass;
    int unsigned n_total;

    rv64_single_cycle_processor dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_x3;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        else
            n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        // x1 = a, x2 = b, destination x3 preset to 0xDEAD before each vector
        vecs[0] = '{"add_wrap", 32'h002081B3, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0};
        vecs[1] = '{"add_ovf",  32'h002081B3, 64'h7FFFFFFFFFFFFFFF, 64'h1, 64'h8000000000000000};
        vecs[2] = '{"sub_neg",  32'h402081B3, 64'h5, 64'h7, 64'hFFFFFFFFFFFFFFFE};
        vecs[3] = '{"sub_zero", 32'h402081B3, 64'h1234, 64'h1234, 64'h0};
        vecs[4] = '{"and",      32'h0020F1B3, 64'hF0F0F0F0F0F0F0F0, 64'h0FF00FF00FF00FF0, 64'h00F000F000F000F0};
        vecs[5] = '{"or",       32'h0020E1B3, 64'hF0F0F0F0F0F0F0F0, 64'h0FF00FF00FF00FF0, 64'hFFF0FFF0FFF0FFF0};
        vecs[6] = '{"addi_m1",  32'hFFF08193, 64'h10, 64'h0, 64'hF};
        vecs[7] = '{"addi_max", 32'h7FF08193, 64'h1, 64'h0, 64'h800};
        vecs[8] = '{"ld_wrap",  32'hFF80B183, 64'h808, 64'h0, 64'hCAFE};
        vecs[9] = '{"lui_nop",  32'h002081B7, 64'h1, 64'h2, 64'hDEAD};

        // Test-plan program, preloaded while reset is held
        reset = 1'b0;
        #1;
        dut.if_stage.instr_mem[0] <= 32'h00073A03;
        dut.if_stage.instr_mem[1] <= 32'h00530AB3;
        dut.if_stage.instr_mem[2] <= 32'h01583023;
        dut.if_stage.instr_mem[3] <= 32'h01288863;
        dut.if_stage.instr_mem[7] <= 32'h00500013;
        dut.if_stage.instr_mem[8] <= 32'h00000000;
        dut.id_stage.registers[0]  <= 64'h0;
        dut.id_stage.registers[5]  <= 64'h5;
        dut.id_stage.registers[6]  <= 64'h6;
        dut.id_stage.registers[14] <= 64'h100;
        dut.id_stage.registers[16] <= 64'h200;
        dut.id_stage.registers[17] <= 64'h1;
        dut.id_stage.registers[18] <= 64'h1;
        dut.id_stage.registers[20] <= 64'h0;
        dut.id_stage.registers[21] <= 64'h0;
        dut.mem_stage.mem[32] <= 64'h1234567890ABCDEF;
        dut.mem_stage.mem[64] <= 64'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pc", dut.pc_current, 64'h0);
        check("reset_no_regwrite", dut.id_stage.registers[20], 64'h0);

        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("ld_x20", dut.id_stage.registers[20], 64'h1234567890ABCDEF);
        check("ld_pc", dut.pc_current, 64'h4);
        @(posedge clk); #1;
        check("add_x21", dut.id_stage.registers[21], 64'hB);
        check("add_pc", dut.pc_current, 64'h8);
        @(posedge clk); #1;
        check("sd_mem64", dut.mem_stage.mem[64], 64'hB);
        @(negedge clk);
        check("beq_taken_flag", {63'h0, dut.branch_taken}, 64'h1);
        check("beq_imm", dut.imm_ext, 64'h10);
        @(posedge clk); #1;
        check("beq_taken_pc", dut.pc_current, 64'h1C);
        @(posedge clk); #1;
        check("x0_stays_zero", dut.id_stage.registers[0], 64'h0);
        check("addi_x0_pc", dut.pc_current, 64'h20);
        @(posedge clk); #1;
        check("nop_pc", dut.pc_current, 64'h24);
        check("nop_x20", dut.id_stage.registers[20], 64'h1234567890ABCDEF);
        check("nop_x21", dut.id_stage.registers[21], 64'hB);
        check("nop_mem64", dut.mem_stage.mem[64], 64'hB);

        // Asynchronous reset between edges
        #2 reset = 1'b0;
        #1;
        check("midrun_reset_pc", dut.pc_current, 64'h0);
        check("midrun_x14", dut.id_stage.registers[14], 64'h100);
        check("midrun_mem32", dut.mem_stage.mem[32], 64'h1234567890ABCDEF);
        dut.if_stage.instr_mem[0] <= 32'h01288863;
        dut.id_stage.registers[18] <= 64'h2;
        @(negedge clk) reset = 1'b1;
        #1;
        check("beq_not_taken_flag", {63'h0, dut.branch_taken}, 64'h0);
        @(posedge clk); #1;
        check("beq_not_taken_pc", dut.pc_current, 64'h4);

        // Table of single-instruction vectors, one per PC slot
        @(negedge clk) reset = 1'b0;
        #1;
        for (int i = 0; i < 10; i++)
            dut.if_stage.instr_mem[i] <= vecs[i].instr;
        dut.mem_stage.mem[0] <= 64'hCAFE;
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            dut.id_stage.registers[1] <= vecs[i].a;
            dut.id_stage.registers[2] <= vecs[i].b;
            dut.id_stage.registers[3] <= 64'hDEAD;
            @(posedge clk); #1;
            check(vecs[i].name, dut.id_stage.registers[3], vecs[i].exp_x3);
            check({vecs[i].name, "_pc"}, dut.pc_current, 64'(4 * (i + 1)));
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
